// File: rtl/modes_uplink_capture.sv
// Mode S uplink (P6) frame capture: bit shift-in, on-the-fly 24-bit parity,
// address recovery from AP, and a one-deep valid/ready output register.
module modes_uplink_capture #(
  parameter int MAX_BITS = 112,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                frame_end,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                out_long,
  output logic [4:0]          out_uf,
  output logic [MAX_BITS-1:0] out_bits,
  output logic [23:0]         out_addr,
  output logic                out_len_err,
  output logic                overrun,
  output logic                abort
);

  // Handshake: a frame moves out on a rising clk edge where out_valid && out_ready;
  // while out_valid && !out_ready every out_* field holds its value.

  typedef enum logic [1:0] {IDLE, RECV, EVAL} state_t;

  localparam logic [23:0]      POLY    = 24'hFFF409;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_S   = CNT_W'(32);
  localparam logic [CNT_W-1:0] CNT_L   = CNT_W'(88);
  localparam logic [CNT_W-1:0] LEN_S   = CNT_W'(56);
  localparam logic [CNT_W-1:0] LEN_L   = CNT_W'(112);
  localparam logic [CNT_W-1:0] UF_OFS  = CNT_W'(5);

  state_t state, state_next;

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [MAX_BITS-1:0] shift_reg, shift_n;
  logic [23:0]         crc, crc_n, crc_s, crc_s_n, crc_l, crc_l_n;

  logic                clear, take_bit, fb;
  logic [CNT_W-1:0]    cnt_base;
  logic [MAX_BITS-1:0] shift_base;
  logic [23:0]         crc_base, crc_step;

  logic                len_ok, is_long;
  logic [4:0]          uf_calc;
  logic [23:0]         addr_calc;

  logic                res_pending, res_long, res_len_err;
  logic [4:0]          res_uf;
  logic [MAX_BITS-1:0] res_bits;
  logic [23:0]         res_addr;
  logic                commit;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = RECV;
      RECV:    if (!frame_start && frame_end) state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A frame_start in IDLE or RECV restarts capture; a bit in the same cycle is bit 1.
  always_comb begin
    clear      = frame_start && (state == IDLE || state == RECV);
    take_bit   = bit_valid && ((state == RECV) || (state == IDLE && frame_start));
    cnt_base   = clear ? '0 : cnt;
    shift_base = clear ? '0 : shift_reg;
    crc_base   = clear ? '0 : crc;
    fb         = crc_base[23] ^ bit_in;
    crc_step   = {crc_base[22:0], 1'b0} ^ (fb ? POLY : 24'h0);

    cnt_n   = cnt_base;
    shift_n = shift_base;
    crc_n   = crc_base;
    crc_s_n = clear ? 24'h0 : crc_s;
    crc_l_n = clear ? 24'h0 : crc_l;
    if (take_bit) begin
      if (cnt_base < CNT_L)     crc_n   = crc_step;
      if (cnt_base < CNT_MAX)   shift_n = {shift_base[MAX_BITS-2:0], bit_in};
      if (cnt_base != CNT_SAT)  cnt_n   = cnt_base + 1'b1;
      if (cnt_base == CNT_S - 1'b1) crc_s_n = crc_step;
      if (cnt_base == CNT_L - 1'b1) crc_l_n = crc_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shift_reg <= '0;
      crc       <= '0;
      crc_s     <= '0;
      crc_l     <= '0;
    end else begin
      cnt       <= cnt_n;
      shift_reg <= shift_n;
      crc       <= crc_n;
      crc_s     <= crc_s_n;
      crc_l     <= crc_l_n;
    end
  end

  // Frame evaluation from the final bit count
  always_comb begin
    len_ok    = (cnt == LEN_S) || (MAX_BITS == 112 && cnt == LEN_L);
    is_long   = (cnt == LEN_L);
    uf_calc   = 5'(shift_reg >> (cnt - UF_OFS));
    addr_calc = (is_long ? crc_l : crc_s) ^ shift_reg[23:0];
  end

  // EVAL result is staged one cycle, then committed to the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_pending <= 1'b0;
      res_long    <= 1'b0;
      res_uf      <= '0;
      res_bits    <= '0;
      res_addr    <= '0;
      res_len_err <= 1'b0;
    end else begin
      res_pending <= (state == EVAL);
      if (state == EVAL) begin
        res_long    <= is_long;
        res_uf      <= len_ok ? uf_calc : 5'h0;
        res_bits    <= shift_reg;
        res_addr    <= len_ok ? addr_calc : 24'h0;
        res_len_err <= !len_ok;
      end
    end
  end

  assign commit = res_pending && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_long    <= 1'b0;
      out_uf      <= '0;
      out_bits    <= '0;
      out_addr    <= '0;
      out_len_err <= 1'b0;
      overrun     <= 1'b0;
      abort       <= 1'b0;
    end else begin
      abort <= (state == RECV) && frame_start;
      if (commit) begin
        out_valid   <= 1'b1;
        out_long    <= res_long;
        out_uf      <= res_uf;
        out_bits    <= res_bits;
        out_addr    <= res_addr;
        out_len_err <= res_len_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (res_pending && !commit) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_modes_uplink_capture.sv
// Directed bench for modes_uplink_capture: 112-bit and 56-bit instances,
// expected frames queued at stimulus time and popped by output monitors.
module tb_modes_uplink_capture;

  typedef struct packed {
    logic         lng;
    logic [4:0]   uf;
    logic [111:0] bits;
    logic [23:0]  addr;
    logic         len_err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         frame_start, bit_in, bit_valid, frame_end, out_ready;
  logic         out_valid, out_long, out_len_err, overrun, abort;
  logic [4:0]   out_uf;
  logic [111:0] out_bits;
  logic [23:0]  out_addr;

  logic         fs56, bit56, bv56, fe56, rdy56;
  logic         ov56, ol56, oerr56, orun56, ab56;
  logic [4:0]   ouf56;
  logic [55:0]  obits56;
  logic [23:0]  oaddr56;

  int n_vec = 0;
  int n_err = 0;
  int abort_cnt = 0;
  int target = 0;

  exp_t exp_q[$];
  exp_t exp56_q[$];
  exp_t mon_e, mon56_e;

  modes_uplink_capture #(.MAX_BITS(112), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .frame_end(frame_end), .out_ready(out_ready),
    .out_valid(out_valid), .out_long(out_long), .out_uf(out_uf), .out_bits(out_bits),
    .out_addr(out_addr), .out_len_err(out_len_err), .overrun(overrun), .abort(abort)
  );

  modes_uplink_capture #(.MAX_BITS(56), .CNT_W(8)) dut56 (
    .clk(clk), .reset(reset), .frame_start(fs56), .bit_in(bit56),
    .bit_valid(bv56), .frame_end(fe56), .out_ready(rdy56),
    .out_valid(ov56), .out_long(ol56), .out_uf(ouf56), .out_bits(obits56),
    .out_addr(oaddr56), .out_len_err(oerr56), .overrun(orun56), .abort(ab56)
  );

  task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Mode S parity as polynomial division of data*x^24 by 0x1FFF409
  function automatic logic [23:0] mode_s_parity(input logic [87:0] data, input int n);
    logic [111:0] w;
    w = 112'(data) << 24;
    for (int i = n + 23; i >= 24; i--)
      if (w[i]) w = w ^ (112'(25'h1FFF409) << (i - 24));
    return w[23:0];
  endfunction

  function automatic exp_t make_exp(input logic [111:0] v, input int n, input int maxb);
    exp_t e;
    logic [111:0] m;
    e = '0;
    m = (n >= 112) ? v : (v & ((112'(1) << n) - 112'(1)));
    if (n == 56 || (n == 112 && maxb == 112)) begin
      e.lng  = (n == 112);
      e.uf   = 5'(m >> (n - 5));
      e.bits = m;
      e.addr = mode_s_parity(88'(m >> 24), n - 24) ^ m[23:0];
    end else begin
      e.len_err = 1'b1;
      e.bits    = (n > maxb) ? (m >> (n - maxb)) : m;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic fs, input logic b, input logic bv, input logic fe);
    if (target == 0) begin
      frame_start = fs; bit_in = b; bit_valid = bv; frame_end = fe;
    end else begin
      fs56 = fs; bit56 = b; bv56 = bv; fe56 = fe;
    end
  endtask

  // Sends an n-bit frame MSB first and returns one cycle after frame_end is sampled.
  task automatic send_frame(input logic [111:0] v, input int n, input bit start_with_bit,
                            input bit gaps, input bit fe_on_last);
    int first;
    if (start_with_bit) begin
      set_in(1'b1, v[n-1], 1'b1, 1'b0);
      first = n - 2;
    end else begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      first = n - 1;
    end
    tick();
    for (int i = first; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          set_in(1'b0, 1'b0, 1'b0, 1'b0);
          tick();
        end
      end
      set_in(1'b0, v[i], 1'b1, (i == 0) && fe_on_last);
      tick();
    end
    if (!fe_on_last) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic send_partial(input logic [111:0] v, input int n, input int k);
    set_in(1'b1, v[n-1], 1'b1, 1'b0);
    tick();
    for (int i = n - 2; i > n - 1 - k; i--) begin
      set_in(1'b0, v[i], 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [111:0] short_frame(input logic [4:0] uf, input logic [26:0] d,
                                               input logic [23:0] ap);
    return 112'({uf, d, ap});
  endfunction

  // Output monitors
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_frame: got bits %h, expected no frame", out_bits);
      end else begin
        mon_e = exp_q.pop_front();
        check("long", 112'(out_long), 112'(mon_e.lng));
        check("uf", 112'(out_uf), 112'(mon_e.uf));
        check("bits", out_bits, mon_e.bits);
        check("addr", 112'(out_addr), 112'(mon_e.addr));
        check("len_err", 112'(out_len_err), 112'(mon_e.len_err));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov56 && rdy56) begin
      if (exp56_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_frame56: got bits %h, expected no frame", obits56);
      end else begin
        mon56_e = exp56_q.pop_front();
        check("long56", 112'(ol56), 112'(mon56_e.lng));
        check("uf56", 112'(ouf56), 112'(mon56_e.uf));
        check("bits56", 112'(obits56), mon56_e.bits);
        check("addr56", 112'(oaddr56), 112'(mon56_e.addr));
        check("len_err56", 112'(oerr56), 112'(mon56_e.len_err));
      end
    end
  end

  always @(negedge clk) if (!reset && abort) abort_cnt++;

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 112'(out_valid), 112'(0));
    check({tag, "_long"}, 112'(out_long), 112'(0));
    check({tag, "_uf"}, 112'(out_uf), 112'(0));
    check({tag, "_bits"}, out_bits, 112'(0));
    check({tag, "_addr"}, 112'(out_addr), 112'(0));
    check({tag, "_len_err"}, 112'(out_len_err), 112'(0));
    check({tag, "_overrun"}, 112'(overrun), 112'(0));
    check({tag, "_abort"}, 112'(abort), 112'(0));
  endtask

  initial begin
    logic [111:0] v1, v2, v3, va, vb, vr, vc, vd, ve;
    exp_t e;
    logic [82:0] rnd83;

    reset = 1'b1;
    frame_start = 0; bit_in = 0; bit_valid = 0; frame_end = 0; out_ready = 1'b1;
    fs56 = 0; bit56 = 0; bv56 = 0; fe56 = 0; rdy56 = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Short frame, latency check
    v1 = short_frame(5'b00100, 27'h0, mode_s_parity(88'(32'h2000_0000), 32) ^ 24'hABCDEF);
    e = '0; e.uf = 5'd4; e.bits = v1; e.addr = 24'hABCDEF;
    exp_q.push_back(e);
    send_frame(v1, 56, 1'b1, 1'b0, 1'b0);
    check("latency_t1", 112'(out_valid), 112'(0));
    tick();
    check("latency_t2", 112'(out_valid), 112'(1));

    // Long frame, frame_end on the last bit
    rnd83 = {$urandom, $urandom, 19'($urandom)};
    v2 = {5'b10000, rnd83, 24'h0};
    v2[23:0] = mode_s_parity(88'(v2 >> 24), 88) ^ 24'h123456;
    e = '0; e.lng = 1'b1; e.uf = 5'b10000; e.bits = v2; e.addr = 24'h123456;
    exp_q.push_back(e);
    send_frame(v2, 112, 1'b1, 1'b0, 1'b1);

    // 60-bit frame: length error
    v3 = 112'({$urandom, 28'($urandom)});
    e = '0; e.len_err = 1'b1; e.bits = v3;
    exp_q.push_back(e);
    send_frame(v3, 60, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // 56-bit instance: good short frame, then an over-length 112-bit frame
    target = 1;
    e = '0; e.uf = 5'd4; e.bits = v1; e.addr = 24'hABCDEF;
    exp56_q.push_back(e);
    send_frame(v1, 56, 1'b1, 1'b0, 1'b0);
    e = '0; e.len_err = 1'b1; e.bits = v2 >> 56;
    exp56_q.push_back(e);
    send_frame(v2, 112, 1'b1, 1'b0, 1'b0);
    target = 0;
    repeat (3) tick();

    // Backpressure: second frame dropped, first held
    check("overrun_before", 112'(overrun), 112'(0));
    out_ready = 1'b0;
    va = short_frame(5'b00001, 27'($urandom), 24'($urandom));
    vb = short_frame(5'b11000, 27'($urandom), 24'($urandom));
    exp_q.push_back(make_exp(va, 56, 112));
    send_frame(va, 56, 1'b1, 1'b0, 1'b0);
    send_frame(vb, 56, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check("bp_overrun", 112'(overrun), 112'(1));
    check("bp_valid", 112'(out_valid), 112'(1));
    check("bp_held_bits", out_bits, va);
    out_ready = 1'b1;
    tick();
    check("bp_release", 112'(out_valid), 112'(0));

    // Restart after 20 bits, then a gapped frame
    check("abort_before", 112'(abort_cnt), 112'(0));
    send_partial(112'({$urandom, $urandom}), 56, 20);
    vr = short_frame(5'b01011, 27'($urandom), 24'($urandom));
    exp_q.push_back(make_exp(vr, 56, 112));
    send_frame(vr, 56, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("abort_count", 112'(abort_cnt), 112'(1));

    // Reset at bit 40 with a held frame pending
    out_ready = 1'b0;
    vc = short_frame(5'b00111, 27'($urandom), 24'($urandom));
    send_frame(vc, 56, 1'b1, 1'b0, 1'b0);
    vd = short_frame(5'b01100, 27'($urandom), 24'($urandom));
    send_partial(vd, 56, 40);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    ve = short_frame(5'b10101, 27'($urandom), 24'($urandom));
    exp_q.push_back(make_exp(ve, 56, 112));
    send_frame(ve, 56, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check("abort_after_reset", 112'(abort_cnt), 112'(1));
    check("queue_drained", 112'(exp_q.size()), 112'(0));
    check("queue56_drained", 112'(exp56_q.size()), 112'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modes_uplink_capture.md
# modes_uplink_capture

Parametrised Mode S uplink (P6) frame capture for the DPSK receive path: it collects demodulated bits under an explicit bit-valid strobe, supports both 56-bit short and 112-bit long uplink formats, and computes the 24-bit Mode S parity on the fly to recover the address from the AP field. Captured frames leave through a one-deep valid/ready output register, so the downstream decoder/transponder logic can stall without corrupting the receiver.

## Interface
- MAX_BITS, 112, longest accepted frame; legal values 56 or 112.
- CNT_W, 8, bit-counter width; must hold MAX_BITS+1.

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-high
- frame_start  input  1  one-cycle pulse from the demodulator at the first bit of a P6 block
- bit_in  input  1  demodulated data bit
- bit_valid  input  1  bit_in is valid this cycle
- frame_end  input  1  one-cycle pulse when the demodulator finishes the block
- out_ready  input  1  downstream accepts the output register
- out_valid  output  1  output register holds an unread frame
- out_long  output  1  1 = 112-bit frame, 0 = 56-bit frame
- out_uf  output  5  uplink format, frame bits 1..5
- out_bits  output  MAX_BITS  frame, right-justified; bit 1 of the frame at [N-1], the last bit at [0]; unused upper bits 0
- out_addr  output  24  AP XOR computed parity (the address for address/parity formats)
- out_len_err  output  1  bit count at frame_end was neither 56 nor 112, or exceeded MAX_BITS
- overrun  output  1  sticky; a completed frame was dropped because the output register was full
- abort  output  1  one-cycle pulse when frame_start arrives while in RECV

## Operation
- FSM states: IDLE, RECV, EVAL.
  - IDLE -> RECV on frame_start.
  - RECV -> EVAL on frame_end.
  - EVAL -> IDLE unconditionally after one cycle.
  - frame_start in RECV: pulse abort, clear the counter, shift register and CRC, and stay in RECV.
  - frame_end in IDLE or EVAL: ignored.
- In RECV, each bit_valid does three things:
  - shift_reg <= {shift_reg[MAX_BITS-2:0], bit_in};
  - cnt increments and saturates at MAX_BITS+1;
  - the CRC updates while cnt < 88, before the increment: fb = crc[23]^bit_in; crc <= {crc[22:0],1'b0} ^ (fb ? 24'hFFF409 : 0).
- CRC snapshots:
  - crc_s is latched when cnt becomes 32 (end of short data field).
  - crc_l is latched when cnt becomes 88 (end of long data field).
- Bits beyond MAX_BITS are not shifted in. They only drive cnt to MAX_BITS+1, which forces a length error.
- On frame_start in IDLE, if bit_valid is high in the same cycle, that bit is frame bit 1.
- In RECV, if bit_valid and frame_end coincide, the bit is included.
- EVAL builds the result from N = cnt:
  - len_ok = (N==56) || (N==112 && MAX_BITS==112).
  - out_long = (N==112).
  - out_addr = (long ? crc_l : crc_s) ^ shift_reg[23:0].
  - out_uf = shift_reg[N-1:N-5].
  - For a length error, out_addr and out_uf are 0, out_bits is the raw shift_reg, and out_len_err = 1.
- Output register load rules:
  - It loads in EVAL if out_valid==0, or if out_valid&&out_ready (same-cycle replace).
  - Otherwise the new frame is dropped and overrun is set. Only reset clears overrun.
- Handshake: out_valid clears when out_ready && out_valid and no new load occurs that cycle. Outputs stay stable while out_valid && !out_ready.

## Timing
- Reset values: all outputs 0, FSM IDLE, cnt/shift_reg/crc/crc_s/crc_l 0.
- frame_end sampled at edge t: EVAL during cycle t+1; out_valid is high from edge t+2. Latency is 2 clocks from frame_end to out_valid.
- The earliest next frame_start is accepted in cycle t+2; a frame_start during EVAL is ignored.
- Throughput is one frame per back-to-back frame_end/frame_start gap of 2 cycles or more; bits may arrive every clock.
- Reset asserted mid-frame: immediate return to IDLE, the pending out_valid is lost, and no abort pulse is generated.

## Test plan
- Short frame:
  - Stimulus: frame_start, then 56 bits = UF 5'b00100 + 27 zero bits + AP 24'hABCDEF, then frame_end.
  - Required: out_valid at frame_end+2, out_long=0, out_uf=4, out_addr=24'hABCDEF, out_len_err=0.
- Long frame:
  - Stimulus: 112 bits, UF 5'b10000, random data, AP = golden-model CRC XOR 24'h123456.
  - Required: out_long=1, out_addr=24'h123456, out_bits equal to the sent vector.
- Length error:
  - Stimulus 1: 60 bits, then frame_end. Required: out_len_err=1, out_addr=0.
  - Stimulus 2: with MAX_BITS=56, send 112 bits. Required: out_len_err=1.
- Backpressure:
  - Stimulus: hold out_ready=0 and send two valid short frames.
  - Required: the first frame is held unchanged, the second is dropped, overrun=1. Raising out_ready then clears out_valid after one cycle.
- Restart and gaps:
  - Stimulus: frame_start after 20 bits in RECV, then a full 56-bit frame with bit_valid low on random cycles.
  - Required: an abort pulse, then a correct capture of only the second frame.
- Reset mid-frame:
  - Stimulus: assert reset at bit 40.
  - Required: all outputs 0 immediately, and the next complete frame captures correctly.
